// File: rtl/cpu_instr_loader.sv
// Boot loader for the CPU instruction memory: receives a length-framed byte stream,
// writes big-endian 32-bit words from address 0, and releases CPU reset on a good checksum.
module cpu_instr_loader #(
   parameter int ADDR_W    = 16,
   parameter int MAX_WORDS = 16384
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_req,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_rst_n,
   output logic              done,
   output logic              err
);

   // state    | meaning
   // S_LEN_HI | waiting for word-count high byte
   // S_LEN_LO | waiting for word-count low byte; range check
   // S_DATA   | assembling data bytes into words, accumulating checksum
   // S_CSUM   | waiting for checksum byte
   // S_DONE   | load good, CPU released; waits for load_req
   // S_ERR    | load failed, CPU held in reset; waits for load_req
   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t      state;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] word_buf;
   logic [7:0]  csum;

   logic        accept;
   logic [15:0] len_next;

   assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CSUM);
   assign accept   = in_valid && in_ready;
   assign len_next = {len[15:8], in_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_LEN_HI;
         len       <= '0;
         word_idx  <= '0;
         byte_cnt  <= '0;
         word_buf  <= '0;
         csum      <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         cpu_rst_n <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_LEN_HI: begin
               if (accept) begin
                  len[15:8] <= in_data;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= in_data;
                  if ({1'b0, len_next} > MAX_LEN) begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end else if (len_next == 16'd0) begin
                     state <= S_CSUM;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  csum     <= csum ^ in_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  word_buf <= {word_buf[15:0], in_data};
                  // Fourth byte: the word leaves on wr_en in the next cycle
                  if (byte_cnt == 2'd3) begin
                     wr_en    <= 1'b1;
                     wr_data  <= {word_buf, in_data};
                     wr_addr  <= ADDR_W'({word_idx, 2'b00});
                     word_idx <= word_idx + 16'd1;
                     if (word_idx + 16'd1 == len) begin
                        state <= S_CSUM;
                     end
                  end
               end
            end
            S_CSUM: begin
               if (accept) begin
                  if (in_data == csum) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     cpu_rst_n <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
            S_DONE, S_ERR: begin
               if (load_req) begin
                  state     <= S_LEN_HI;
                  done      <= 1'b0;
                  err       <= 1'b0;
                  cpu_rst_n <= 1'b0;
                  len       <= '0;
                  word_idx  <= '0;
                  byte_cnt  <= '0;
                  word_buf  <= '0;
                  csum      <= '0;
               end
            end
            default: state <= S_LEN_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_instr_loader.sv
// Directed bench for cpu_instr_loader: nominal, empty, bad checksum, length limits,
// backpressure, mid-load reset and reload.
module tb_cpu_instr_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_req;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_rst_n;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;
   wr_t wq[$];

   cpu_instr_loader #(.ADDR_W(16), .MAX_WORDS(16384)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_req  (load_req),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_rst_n (cpu_rst_n),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en === 1'b1) wq.push_back('{addr: wr_addr, data: wr_data, cyc: cyc});
   end

   logic [7:0] nominal[$] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                              8'h01, 8'h02, 8'h03, 8'h04, 8'h26};

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_byte_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
      end
      @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] f[$], input bit gaps);
      foreach (f[i]) send_byte(f[i], gaps ? int'($urandom_range(0, 2)) : 0);
   endtask

   task automatic settle();
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1;
   endtask

   task automatic restart();
      @(negedge clk);
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, done, err} !== {1'b1, 1'b0, 16'h0, 32'h0, 3'b000}) begin
         n_fail++;
         $display("FAIL reset_values: rdy=%b wr_en=%b addr=%h data=%h cpu_rst_n=%b done=%b err=%b required 1 0 0000 00000000 0 0 0",
                  in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, done, err);
      end
   endtask

   task automatic test_nominal();
      logic [15:0] ea[2] = '{16'h0000, 16'h0004};
      logic [31:0] ed[2] = '{32'hDEADBEEF, 32'h01020304};
      wq.delete();
      send_frame(nominal, 1'b0);
      settle();
      n_checks++;
      if (wq.size() != 2) begin
         n_fail++;
         $display("FAIL nominal_write_count: got %0d required 2", wq.size());
      end
      for (int i = 0; i < 2 && i < wq.size(); i++) begin
         n_checks++;
         if (wq[i].addr !== ea[i] || wq[i].data !== ed[i]) begin
            n_fail++;
            $display("FAIL nominal_write%0d: got %h/%h required %h/%h", i, wq[i].addr, wq[i].data, ea[i], ed[i]);
         end
      end
      if (wq.size() == 2) begin
         n_checks++;
         if (wq[1].cyc - wq[0].cyc != 4) begin
            n_fail++;
            $display("FAIL nominal_write_spacing: got %0d cycles required 4", wq[1].cyc - wq[0].cyc);
         end
      end
      n_checks++;
      if ({done, cpu_rst_n, err, in_ready} !== 4'b1100) begin
         n_fail++;
         $display("FAIL nominal_result: done=%b cpu_rst_n=%b err=%b rdy=%b required 1 1 0 0", done, cpu_rst_n, err, in_ready);
      end
   endtask

   task automatic test_reload();
      logic [7:0] f[$] = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      wq.delete();
      // byte presented with load_req in S_DONE must not be consumed
      @(negedge clk);
      load_req = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
      @(posedge clk);
      #1;
      load_req = 1'b0; in_valid = 1'b0;
      n_checks++;
      if ({cpu_rst_n, done, in_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL reload_restart: cpu_rst_n=%b done=%b rdy=%b required 0 0 1", cpu_rst_n, done, in_ready);
      end
      send_frame(f, 1'b0);
      settle();
      n_checks++;
      if (wq.size() != 1 || wq[0].addr !== 16'h0000 || wq[0].data !== 32'h11223344) begin
         n_fail++;
         $display("FAIL reload_write: count=%0d first=%h/%h required 1 0000/11223344", wq.size(),
                  wq.size() > 0 ? wq[0].addr : 16'hxxxx, wq.size() > 0 ? wq[0].data : 32'hx);
      end
      n_checks++;
      if ({done, cpu_rst_n, err} !== 3'b110) begin
         n_fail++;
         $display("FAIL reload_result: done=%b cpu_rst_n=%b err=%b required 1 1 0", done, cpu_rst_n, err);
      end
   endtask

   task automatic test_empty();
      logic [7:0] f[$] = '{8'h00, 8'h00, 8'h00};
      restart();
      wq.delete();
      send_frame(f, 1'b0);
      settle();
      n_checks++;
      if (wq.size() != 0 || {done, cpu_rst_n, err} !== 3'b110) begin
         n_fail++;
         $display("FAIL empty_program: writes=%0d done=%b cpu_rst_n=%b err=%b required 0 1 1 0", wq.size(), done, cpu_rst_n, err);
      end
   endtask

   task automatic test_bad_csum();
      logic [7:0] f[$];
      f = nominal;
      f[10] = 8'h27;
      restart();
      wq.delete();
      send_frame(f, 1'b0);
      settle();
      n_checks++;
      if (wq.size() != 2) begin
         n_fail++;
         $display("FAIL bad_csum_writes: got %0d required 2", wq.size());
      end
      n_checks++;
      if ({err, done, cpu_rst_n, in_ready} !== 4'b1000) begin
         n_fail++;
         $display("FAIL bad_csum_result: err=%b done=%b cpu_rst_n=%b rdy=%b required 1 0 0 0", err, done, cpu_rst_n, in_ready);
      end
   endtask

   task automatic test_length_limits();
      restart();
      wq.delete();
      send_byte(8'h40, 0);
      send_byte(8'h01, 0);
      #1;
      n_checks++;
      if ({err, in_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL oversize_len: err=%b rdy=%b required 1 0", err, in_ready);
      end
      settle();
      n_checks++;
      if (wq.size() != 0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL oversize_no_write: writes=%0d done=%b required 0 0", wq.size(), done);
      end
      restart();
      send_byte(8'h40, 0);
      send_byte(8'h00, 0);
      settle();
      n_checks++;
      if ({err, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL max_len_accepted: err=%b rdy=%b required 0 1", err, in_ready);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] f[$] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wq.delete();
      send_frame(f, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, done, err} !== {1'b1, 1'b0, 16'h0, 32'h0, 3'b000}) begin
         n_fail++;
         $display("FAIL mid_reset_values: rdy=%b wr_en=%b addr=%h data=%h cpu_rst_n=%b done=%b err=%b required 1 0 0000 00000000 0 0 0",
                  in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, done, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (wq.size() != 1 || wq[0].addr !== 16'h0000 || wq[0].data !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL mid_reset_writes: count=%0d required 1 at 0000/DEADBEEF", wq.size());
      end
      wq.delete();
      send_frame(nominal, 1'b0);
      settle();
      n_checks++;
      if (wq.size() != 2 || wq[1].addr !== 16'h0004 || wq[1].data !== 32'h01020304 || done !== 1'b1 || cpu_rst_n !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_reload: writes=%0d done=%b cpu_rst_n=%b required 2 1 1", wq.size(), done, cpu_rst_n);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] ea[2] = '{16'h0000, 16'h0004};
      logic [31:0] ed[2] = '{32'hDEADBEEF, 32'h01020304};
      restart();
      wq.delete();
      send_frame(nominal, 1'b1);
      settle();
      n_checks++;
      if (wq.size() != 2) begin
         n_fail++;
         $display("FAIL backpressure_write_count: got %0d required 2", wq.size());
      end
      for (int i = 0; i < 2 && i < wq.size(); i++) begin
         n_checks++;
         if (wq[i].addr !== ea[i] || wq[i].data !== ed[i]) begin
            n_fail++;
            $display("FAIL backpressure_write%0d: got %h/%h required %h/%h", i, wq[i].addr, wq[i].data, ea[i], ed[i]);
         end
      end
      n_checks++;
      if ({done, cpu_rst_n, err} !== 3'b110) begin
         n_fail++;
         $display("FAIL backpressure_result: done=%b cpu_rst_n=%b err=%b required 1 1 0", done, cpu_rst_n, err);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_reload();
      test_empty();
      test_bad_csum();
      test_length_limits();
      test_mid_reset();
      test_backpressure();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
